// File: rtl/ace_ack_tracker.sv
// ACE outstanding-transaction tracker: throttles AR/AW, counts RACK/WACK, drains on flush.
// Optional sticky protocol error output enabled by ACE_ACK_TRACKER_ERR_EN.
module ace_ack_tracker #(
  parameter int unsigned MaxRTrans = 8,
  parameter int unsigned MaxWTrans = 8,
  parameter bit          RegAck    = 1'b0,
  localparam int unsigned RW = $clog2(MaxRTrans + 1),
  localparam int unsigned WW = $clog2(MaxWTrans + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          slv_ar_valid_i,
  output logic          slv_ar_ready_o,
  output logic          mst_ar_valid_o,
  input  logic          mst_ar_ready_i,
  input  logic          slv_aw_valid_i,
  output logic          slv_aw_ready_o,
  output logic          mst_aw_valid_o,
  input  logic          mst_aw_ready_i,
  input  logic          r_valid_i,
  input  logic          r_ready_i,
  input  logic          r_last_i,
  input  logic          b_valid_i,
  input  logic          b_ready_i,
  input  logic          rack_i,
  input  logic          wack_i,
  input  logic          flush_i,
  output logic          flush_done_o,
`ifdef ACE_ACK_TRACKER_ERR_EN
  output logic          err_o,
`endif
  output logic [RW-1:0] r_cnt_o,
  output logic [WW-1:0] w_cnt_o,
  output logic [RW-1:0] r_pend_o,
  output logic [WW-1:0] w_pend_o
);

  localparam logic [RW-1:0] RMax = RW'(MaxRTrans);
  localparam logic [WW-1:0] WMax = WW'(MaxWTrans);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE,
    HOLD
  } state_e;

  state_e        state;
  logic [RW-1:0] r_cnt, r_pend;
  logic [WW-1:0] w_cnt, w_pend;
  logic          rack_q, wack_q;
  logic          rack, wack;
  logic          allow_r, allow_w;
  logic          ar_hs, aw_hs, rl_hs, b_hs;
  logic          r_dec, w_dec, rp_inc, wp_inc;

  assign allow_r = (r_cnt < RMax) && (state == IDLE);
  assign allow_w = (w_cnt < WMax) && (state == IDLE);

  assign mst_ar_valid_o = slv_ar_valid_i & allow_r;
  assign slv_ar_ready_o = mst_ar_ready_i & allow_r;
  assign mst_aw_valid_o = slv_aw_valid_i & allow_w;
  assign slv_aw_ready_o = mst_aw_ready_i & allow_w;

  assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
  assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign rl_hs = r_valid_i & r_ready_i & r_last_i;
  assign b_hs  = b_valid_i & b_ready_i;

  assign rack = RegAck ? rack_q : rack_i;
  assign wack = RegAck ? wack_q : wack_i;

  // Acks without a pending response, and responses without an issue, are dropped.
  assign r_dec  = rack && (r_pend != '0);
  assign w_dec  = wack && (w_pend != '0);
  assign rp_inc = rl_hs && (r_pend != r_cnt);
  assign wp_inc = b_hs && (w_pend != w_cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rack_q <= 1'b0;
      wack_q <= 1'b0;
    end else begin
      rack_q <= rack_i;
      wack_q <= wack_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_pend <= '0;
      w_cnt  <= '0;
      w_pend <= '0;
    end else begin
      if (ar_hs && !r_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!ar_hs && r_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (rp_inc && !r_dec) begin
        r_pend <= r_pend + 1'b1;
      end else if (!rp_inc && r_dec) begin
        r_pend <= r_pend - 1'b1;
      end
      if (aw_hs && !w_dec) begin
        w_cnt <= w_cnt + 1'b1;
      end else if (!aw_hs && w_dec) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (wp_inc && !w_dec) begin
        w_pend <= w_pend + 1'b1;
      end else if (!wp_inc && w_dec) begin
        w_pend <= w_pend - 1'b1;
      end
    end
  end

  // Once a drain starts it runs to completion even if flush_i drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_i) state <= DRAIN;
        end
        DRAIN: begin
          if (r_cnt == '0 && w_cnt == '0) begin
            state        <= DONE;
            flush_done_o <= 1'b1;
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!flush_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACE_ACK_TRACKER_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if ((rack && r_pend == '0) ||
                 (wack && w_pend == '0) ||
                 (rl_hs && r_pend == r_cnt) ||
                 (b_hs && w_pend == w_cnt)) begin
      err_o <= 1'b1;
    end
  end
`endif

  assign r_cnt_o  = r_cnt;
  assign w_cnt_o  = w_cnt;
  assign r_pend_o = r_pend;
  assign w_pend_o = w_pend;

endmodule

// File: tb/tb_ace_ack_tracker.sv
// Directed bench for ace_ack_tracker: gating, ack retire, flush drain, async reset.
// A second instance with RegAck=1 shares the stimulus for the delayed-ack check.
module tb_ace_ack_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ar_valid = 0, ar_ready = 0, aw_valid = 0, aw_ready = 0;
  logic r_valid = 0, r_ready = 0, r_last = 0;
  logic b_valid = 0, b_ready = 0;
  logic rack = 0, wack = 0, flush = 0;

  logic       s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid, done;
  logic [3:0] r_cnt, w_cnt, r_pend, w_pend;
  logic       s_ar_ready2, m_ar_valid2, s_aw_ready2, m_aw_valid2, done2;
  logic [3:0] r_cnt2, w_cnt2, r_pend2, w_pend2;
`ifdef ACE_ACK_TRACKER_ERR_EN
  logic err, err2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ace_ack_tracker #(.MaxRTrans(8), .MaxWTrans(8), .RegAck(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(s_ar_ready),
    .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(ar_ready),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(s_aw_ready),
    .mst_aw_valid_o(m_aw_valid), .mst_aw_ready_i(aw_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .rack_i(rack), .wack_i(wack), .flush_i(flush),
    .flush_done_o(done),
`ifdef ACE_ACK_TRACKER_ERR_EN
    .err_o(err),
`endif
    .r_cnt_o(r_cnt), .w_cnt_o(w_cnt),
    .r_pend_o(r_pend), .w_pend_o(w_pend)
  );

  ace_ack_tracker #(.MaxRTrans(8), .MaxWTrans(8), .RegAck(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(s_ar_ready2),
    .mst_ar_valid_o(m_ar_valid2), .mst_ar_ready_i(ar_ready),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(s_aw_ready2),
    .mst_aw_valid_o(m_aw_valid2), .mst_aw_ready_i(aw_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .rack_i(rack), .wack_i(wack), .flush_i(flush),
    .flush_done_o(done2),
`ifdef ACE_ACK_TRACKER_ERR_EN
    .err_o(err2),
`endif
    .r_cnt_o(r_cnt2), .w_cnt_o(w_cnt2),
    .r_pend_o(r_pend2), .w_pend_o(w_pend2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {ar_valid, ar_ready, aw_valid, aw_ready} = '0;
    {r_valid, r_ready, r_last, b_valid, b_ready} = '0;
    {rack, wack, flush} = '0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_r_cnt", 32'(r_cnt), 0);
    chk("rst_w_cnt", 32'(w_cnt), 0);
    chk("rst_r_pend", 32'(r_pend), 0);
    chk("rst_w_pend", 32'(w_pend), 0);
    chk("rst_done", 32'(done), 0);
    do_reset();

    // 8 back-to-back ARs then gate
    ar_valid = 1; ar_ready = 1;
    #1;
    chk("ar_pass_valid", 32'(m_ar_valid), 1);
    chk("ar_pass_ready", 32'(s_ar_ready), 1);
    repeat (8) tick();
    chk("ar8_r_cnt", 32'(r_cnt), 8);
    chk("ar9_valid", 32'(m_ar_valid), 0);
    chk("ar9_ready", 32'(s_ar_ready), 0);
    tick();
    chk("ar9_hold_cnt", 32'(r_cnt), 8);

    // single read: 4 beats, RACK next cycle
    do_reset();
    ar_valid = 1; ar_ready = 1;
    tick();
    ar_valid = 0;
    chk("rd_cnt1", 32'(r_cnt), 1);
    r_valid = 1; r_ready = 1;
    repeat (3) tick();
    chk("rd_pend_mid", 32'(r_pend), 0);
    r_last = 1;
    tick();
    {r_valid, r_last} = '0;
    chk("rd_pend1", 32'(r_pend), 1);
    chk("rd_cnt_b4ack", 32'(r_cnt), 1);
    rack = 1;
    tick();
    rack = 0;
    chk("rd_pend0", 32'(r_pend), 0);
    chk("rd_cnt0", 32'(r_cnt), 0);
    chk("regack_pend_late", 32'(r_pend2), 1);
    chk("regack_cnt_late", 32'(r_cnt2), 1);
    tick();
    chk("regack_pend0", 32'(r_pend2), 0);
    chk("regack_cnt0", 32'(r_cnt2), 0);

    // same-cycle AW handshake and WACK
    do_reset();
    aw_valid = 1; aw_ready = 1;
    repeat (3) tick();
    aw_valid = 0;
    b_valid = 1; b_ready = 1;
    tick();
    b_valid = 0;
    chk("wr_cnt3", 32'(w_cnt), 3);
    chk("wr_pend1", 32'(w_pend), 1);
    aw_valid = 1; wack = 1;
    tick();
    aw_valid = 0; wack = 0;
    chk("aw_wack_cnt", 32'(w_cnt), 3);
    chk("aw_wack_pend", 32'(w_pend), 0);

    // spurious WACK with nothing pending
    wack = 1;
    tick();
    wack = 0;
    chk("spur_wack_cnt", 32'(w_cnt), 3);
    chk("spur_wack_pend", 32'(w_pend), 0);
`ifdef ACE_ACK_TRACKER_ERR_EN
    chk("err_set", 32'(err), 1);
    tick();
    chk("err_sticky", 32'(err), 1);
`endif

    // flush with r_cnt=2, w_cnt=1
    do_reset();
    ar_valid = 1; ar_ready = 1; aw_valid = 1; aw_ready = 1;
    tick();
    aw_valid = 0;
    tick();
    ar_valid = 0;
    r_valid = 1; r_ready = 1; r_last = 1;
    repeat (2) tick();
    {r_valid, r_last} = '0;
    b_valid = 1; b_ready = 1;
    tick();
    b_valid = 0;
    chk("fl_r_cnt", 32'(r_cnt), 2);
    chk("fl_w_cnt", 32'(w_cnt), 1);
    chk("fl_r_pend", 32'(r_pend), 2);
    flush = 1;
    tick();
    ar_valid = 1; aw_valid = 1; rack = 1;
    #1;
    chk("drain_ar_valid", 32'(m_ar_valid), 0);
    chk("drain_ar_ready", 32'(s_ar_ready), 0);
    chk("drain_aw_valid", 32'(m_aw_valid), 0);
    chk("drain_aw_ready", 32'(s_aw_ready), 0);
    tick();
    rack = 0;
    chk("drain_done0a", 32'(done), 0);
    tick();
    wack = 1;
    tick();
    wack = 0;
    chk("drain_w0", 32'(w_cnt), 0);
    tick();
    rack = 1;
    tick();
    rack = 0;
    chk("drain_r0", 32'(r_cnt), 0);
    chk("drain_done0b", 32'(done), 0);
    tick();
    chk("flush_done", 32'(done), 1);
    tick();
    chk("flush_done_pulse", 32'(done), 0);
    chk("hold_ar_blocked", 32'(m_ar_valid), 0);
    chk("hold_cnt", 32'(r_cnt), 0);
    flush = 0;
    tick();
    chk("idle_ar_valid", 32'(m_ar_valid), 1);
    ar_valid = 0; aw_valid = 0;

    // async reset while draining with r_cnt=5
    do_reset();
    ar_valid = 1; ar_ready = 1;
    repeat (5) tick();
    ar_valid = 0;
    flush = 1;
    tick();
    ar_valid = 1;
    #1;
    chk("pre_rst_cnt", 32'(r_cnt), 5);
    chk("pre_rst_gated", 32'(m_ar_valid), 0);
    rst_n = 0;
    #1;
    chk("arst_cnt", 32'(r_cnt), 0);
    chk("arst_idle", 32'(m_ar_valid), 1);
    chk("arst_done", 32'(done), 0);
    flush = 0; ar_valid = 0;
    #2;
    rst_n = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
